shift_reg_sequencer: RTL and testbench
======================================

# shift_reg_sequencer

Command sequencer for the 4-bit universal shift register built from `D_FLIPFLOP` cells.
- Accepts one command at a time: parallel load, shift right N, shift left N, or rotate right N.
- Drives the register's mode-select and serial-input select lines for exactly the required number of clock cycles.
- Reports progress through `BUSY`, `REMAIN` and a one-cycle `DONE` pulse.
- Sits between the testbench or host logic and the register datapath. It contains no data storage of its own.

## Interface
Parameters:
- `CNT_W`, default 3: width of the shift count (maximum count `2^CNT_W-1`).

Ports:
- `CLK` input, 1 bit: single clock; all state updates on posedge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `START` input, 1 bit: command request, sampled on posedge.
- `CMD` input, 2 bits: command, latched at accept. 00 = load, 01 = shift right, 10 = shift left, 11 = rotate right.
- `COUNT` input, `CNT_W` bits: number of shift cycles, latched at accept; ignored for load.
- `MODE` output, 2 bits, registered: register mode. 00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
- `SER_SEL` output, 1 bit, registered: serial input select. 0 = external serial input, 1 = feedback from register LSB (rotate).
- `BUSY` output, 1 bit, registered: high while a command is executing.
- `DONE` output, 1 bit, registered: one-cycle pulse after the last operating cycle.
- `REMAIN` output, `CNT_W` bits, registered: shift cycles still to issue.

## Operation
States: IDLE, LOAD, SHIFT, FIN.

IDLE:
- Outputs: `MODE`=00, `SER_SEL`=0, `BUSY`=0, `DONE`=0.
- `START`=1 accepts the command; `CMD` and `COUNT` are latched.
- CMD=00 → LOAD.
- CMD≠00 with COUNT>0 → SHIFT, with `REMAIN`=COUNT.
- CMD≠00 with COUNT=0 → FIN directly; no shift cycle and `MODE` stays 00.

LOAD:
- One cycle with `MODE`=11 and `BUSY`=1, then → FIN.

SHIFT:
- `MODE` = 01 for CMD 01 and 11, 10 for CMD 10.
- `SER_SEL` = 1 only for CMD 11.
- `BUSY`=1.
- `REMAIN` decrements by 1 each cycle. The cycle in which `REMAIN`=1 is the last shift cycle; then → FIN with `REMAIN`=0.

FIN:
- One cycle with `DONE`=1, `BUSY`=0, `MODE`=00, `SER_SEL`=0.
- `START`=1 in FIN is accepted exactly as in IDLE, so commands can run back to back. Otherwise → IDLE.

Rules:
- `START` during LOAD or SHIFT is ignored. It is not queued.
- `CMD` and `COUNT` changes during execution have no effect.
- `REMAIN` never wraps below 0.

## Timing
- Command accepted at posedge k:
  - Load: `MODE`=11 during cycle k+1; `DONE` during cycle k+2.
  - Shift or rotate, N>0: active `MODE` during cycles k+1..k+N; `DONE` during cycle k+N+1.
  - N=0: `DONE` during cycle k+1.
- Maximum N = `2^CNT_W-1` (7 by default), giving `DONE` at k+8.
- Back to back: a `START` accepted in the FIN cycle gives no gap cycle. The next command's first operating cycle immediately follows `DONE`.
- Reset values, after any posedge with `RESET`=1: state IDLE, `MODE`=00, `SER_SEL`=0, `BUSY`=0, `DONE`=0, `REMAIN`=0, latched CMD/COUNT=0.
- `RESET` has priority over `START` and over an operation in progress. Reset mid-shift stops on that edge and produces no `DONE` pulse.
- All outputs come straight from flops and never glitch combinationally. The `D_FLIPFLOP` clock-to-Q delay applies at the register, not here.

## Configuration
- `SEQ_ABORT_EN` defined:
  - Adds input port `ABORT` (1 bit).
  - `ABORT`=1 at a posedge in LOAD or SHIFT → FIN on that edge. The next cycle has `DONE`=1 and `MODE`=00, and `REMAIN` holds its value at abort.
  - `ABORT` in IDLE or FIN has no effect.
  - `RESET` has priority over `ABORT`; `ABORT` has priority over normal progression.
- `SEQ_ABORT_EN` undefined: no `ABORT` port; every accepted command runs to completion unless `RESET` is asserted.

## Test plan
- Reset: hold `RESET` for 2 cycles during a SHIFT with COUNT=5 → next cycle `MODE`=00, `BUSY`=0, `DONE`=0, `REMAIN`=0, and no `DONE` pulse follows.
- Load: `START` with CMD=00 → exactly 1 cycle `MODE`=11, then `DONE`=1 for 1 cycle; a register with DIN=1010 reads Q=1010.
- Shift left: `START` with CMD=10, COUNT=3 → 3 cycles `MODE`=10, `REMAIN` reading 3,2,1, then `DONE`. After Q=0001 with serial input 0, the register reads 1000.
- Rotate and zero count: CMD=11, COUNT=4 on Q=1001 → 4 cycles `MODE`=01 with `SER_SEL`=1, ending with Q=1001 again. CMD=01, COUNT=0 → `DONE` in cycle k+1 with no non-00 `MODE` cycle.
- Back to back and ignored start: `START` held high continuously with CMD=01, COUNT=2 → repeating pattern 01,01,FIN with no idle gap. `START` pulses during SHIFT start nothing extra.
- Abort (only with `SEQ_ABORT_EN` defined): CMD=01, COUNT=7, `ABORT` at the third shift edge → exactly 3 shift cycles, then `DONE` with `REMAIN`=4.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
// Command sequencer for a 4-bit universal shift register. It accepts one
// command at a time and drives the register's mode and serial-input select
// for exactly the required number of clocks.
//
// Optional feature: define SEQ_ABORT_EN to add the ABORT input, which ends a
// LOAD or SHIFT early and goes straight to FIN.
//
// Ports:
//   CLK      in   clock, all state changes on posedge
//   RESET    in   synchronous active-high reset
//   START    in   command request, accepted in IDLE or FIN
//   CMD      in   00 load, 01 shift right, 10 shift left, 11 rotate right
//   COUNT    in   shift cycles for shift/rotate commands
//   ABORT    in   (SEQ_ABORT_EN only) early termination request
//   MODE     out  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   SER_SEL  out  0 external serial input, 1 register LSB feedback
//   BUSY     out  high while a command executes
//   DONE     out  one-cycle pulse after the last operating cycle
//   REMAIN   out  shift cycles still to issue
//
// state | meaning
// IDLE  | waiting for START, outputs at rest
// LOAD  | single parallel-load cycle
// SHIFT | issuing shift/rotate cycles, REMAIN counts down
// FIN   | DONE pulse, can accept the next command back to back

module shift_reg_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       CMD,
    input  logic [CNT_W-1:0] COUNT,
`ifdef SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic [1:0]       MODE,
    output logic             SER_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] REMAIN
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FIN} state_t;

    state_t           r_state;
    logic [1:0]       r_cmd;
    logic [1:0]       r_mode;
    logic             r_ser_sel;
    logic             r_busy;
    logic             r_done;
    // The latched COUNT lives here and is consumed as it counts down.
    logic [CNT_W-1:0] r_remain;
    logic             w_abort;

`ifdef SEQ_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [1:0] f_shift_mode(input logic [1:0] cmd);
        return (cmd == 2'b10) ? 2'b10 : 2'b01;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_cmd     <= 2'b00;
            r_mode    <= 2'b00;
            r_ser_sel <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_remain  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    r_state   <= S_IDLE;
                    r_mode    <= 2'b00;
                    r_ser_sel <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    if (START) begin
                        r_cmd <= CMD;
                        if (CMD == 2'b00) begin
                            r_state  <= S_LOAD;
                            r_mode   <= 2'b11;
                            r_busy   <= 1'b1;
                            r_remain <= '0;
                        end else if (COUNT != '0) begin
                            r_state   <= S_SHIFT;
                            r_mode    <= f_shift_mode(CMD);
                            r_ser_sel <= (CMD == 2'b11);
                            r_busy    <= 1'b1;
                            r_remain  <= COUNT;
                        end else begin
                            // zero count: no operating cycle, straight to DONE
                            r_state  <= S_FIN;
                            r_done   <= 1'b1;
                            r_remain <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_FIN;
                    r_mode  <= 2'b00;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_SHIFT: begin
                    // REMAIN is at least 1 here, so the decrement never wraps.
                    // On abort the shift issued this cycle still counts.
                    r_remain <= r_remain - CNT_W'(1);
                    if (w_abort || r_remain == CNT_W'(1)) begin
                        r_state   <= S_FIN;
                        r_mode    <= 2'b00;
                        r_ser_sel <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_mode    <= f_shift_mode(r_cmd);
                        r_ser_sel <= (r_cmd == 2'b11);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MODE    = r_mode;
    assign SER_SEL = r_ser_sel;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign REMAIN  = r_remain;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Testbench for shift_reg_sequencer: directed scenarios plus randomized
// stimulus, with every cycle's outputs compared against a command-schedule
// model. A small 4-bit register driven by the DUT's MODE/SER_SEL checks data
// movement.

module tb_shift_reg_sequencer;

    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             START;
    logic [1:0]       CMD;
    logic [CNT_W-1:0] COUNT;
    logic             ABORT;
    logic [1:0]       MODE;
    logic             SER_SEL;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] REMAIN;

    always #5 CLK = ~CLK;

    shift_reg_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .CMD    (CMD),
        .COUNT  (COUNT),
`ifdef SEQ_ABORT_EN
        .ABORT  (ABORT),
`endif
        .MODE   (MODE),
        .SER_SEL(SER_SEL),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .REMAIN (REMAIN)
    );

    typedef struct packed {
        logic [1:0]       mode;
        logic             sel;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] rem;
    } rec_t;

    rec_t cur;
    rec_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   n_done;
    int   n_act;

    // register datapath model driven by the DUT's registered controls
    logic [3:0] r_q = 4'b0000;
    logic [3:0] din = 4'b0000;
    logic [1:0] s_mode = 2'b00;
    logic       s_sel = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [1:0] m, input logic s, input logic b,
                                input logic d, input logic [CNT_W-1:0] r);
        rec_t x;
        x.mode = m; x.sel = s; x.busy = b; x.done = d; x.rem = r;
        return x;
    endfunction

    // On each edge: reset clears everything; an accepted command replaces
    // the schedule with its full list of cycles; otherwise the schedule
    // advances, falling back to rest outputs when empty.
    task automatic model_edge();
        rec_t nxt;
        if (RESET) begin
            q.delete();
            nxt = '0;
        end else if (ABORT && cur.busy) begin
            q.delete();
            nxt = mk(2'b00, 1'b0, 1'b0, 1'b1,
                     (cur.mode == 2'b11) ? cur.rem : CNT_W'(cur.rem - 1));
        end else if (START && !cur.busy) begin
            q.delete();
            if (CMD == 2'b00)
                q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, '0));
            else
                for (int i = int'(COUNT); i > 0; i--)
                    q.push_back(mk((CMD == 2'b10) ? 2'b10 : 2'b01, CMD == 2'b11,
                                   1'b1, 1'b0, CNT_W'(i)));
            q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, '0));
            nxt = q.pop_front();
        end else if (q.size() != 0) begin
            nxt = q.pop_front();
        end else begin
            nxt = mk(2'b00, 1'b0, 1'b0, 1'b0, cur.rem);
        end
        cur = nxt;
    endtask

    task automatic dp_edge();
        logic ser;
        ser = s_sel ? r_q[0] : 1'b0;
        case (s_mode)
            2'b11:   r_q = din;
            2'b01:   r_q = {ser, r_q[3:1]};
            2'b10:   r_q = {r_q[2:0], ser};
            default: r_q = r_q;
        endcase
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        dp_edge();
        @(negedge CLK);
        chk("cycle", 32'({MODE, SER_SEL, BUSY, DONE, REMAIN}), 32'(cur));
        s_mode = MODE;
        s_sel  = SER_SEL;
        if (DONE) n_done++;
        if (MODE != 2'b00) n_act++;
    endtask

    task automatic issue(input logic [1:0] c, input logic [CNT_W-1:0] n);
        START = 1'b1;
        CMD   = c;
        COUNT = n;
        cyc();
        START = 1'b0;
    endtask

    task automatic finish_cmd();
        for (int i = 0; i < 12 && (cur.busy || cur.done); i++) cyc();
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; CMD = 2'b00; COUNT = '0; ABORT = 1'b0;
        cur = '0; n_done = 0; n_act = 0;
        cyc();
        cyc();
        chk("reset_outs", 32'({MODE, SER_SEL, BUSY, DONE, REMAIN}), 32'd0);
        RESET = 1'b0;
        cyc();

        // load 1010
        din = 4'b1010;
        n_act = 0;
        issue(2'b00, 3'd5);
        finish_cmd();
        chk("load_q", 32'(r_q), 32'hA);
        chk("load_act", n_act, 1);

        // shift left 3 from 0001
        din = 4'b0001;
        issue(2'b00, '0);
        finish_cmd();
        n_act = 0;
        issue(2'b10, 3'd3);
        finish_cmd();
        chk("shl_q", 32'(r_q), 32'h8);
        chk("shl_act", n_act, 3);

        // rotate right 4 on 1001
        din = 4'b1001;
        issue(2'b00, '0);
        finish_cmd();
        issue(2'b11, 3'd4);
        finish_cmd();
        chk("rot_q", 32'(r_q), 32'h9);

        // zero count
        n_act = 0;
        n_done = 0;
        issue(2'b01, '0);
        finish_cmd();
        chk("zero_act", n_act, 0);
        chk("zero_done", n_done, 1);

        // back to back with START held
        n_done = 0;
        START = 1'b1; CMD = 2'b01; COUNT = 3'd2;
        repeat (9) cyc();
        START = 1'b0;
        chk("b2b_done", n_done, 3);
        finish_cmd();

        // START pulses during SHIFT are ignored
        n_done = 0;
        issue(2'b01, 3'd5);
        START = 1'b1; CMD = 2'b00;
        cyc();
        START = 1'b0;
        cyc();
        START = 1'b1; CMD = 2'b10; COUNT = 3'd7;
        cyc();
        START = 1'b0;
        finish_cmd();
        chk("ign_done", n_done, 1);

        // reset mid-shift
        issue(2'b01, 3'd5);
        cyc();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
        n_done = 0;
        repeat (8) cyc();
        chk("rst_no_done", n_done, 0);

        // max count
        n_act = 0;
        issue(2'b01, 3'd7);
        finish_cmd();
        chk("max_act", n_act, 7);

`ifdef SEQ_ABORT_EN
        n_act = 0;
        issue(2'b01, 3'd7);
        cyc();
        cyc();
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        chk("abort_rem", 32'(REMAIN), 32'd4);
        chk("abort_done", 32'(DONE), 32'd1);
        chk("abort_act", n_act, 3);
        finish_cmd();
`endif

        // randomized
        for (int i = 0; i < 1500; i++) begin
            RESET = ($urandom_range(0, 99) < 2);
            START = ($urandom_range(0, 2) == 0);
            CMD   = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       COUNT = '0;
                1:       COUNT = '1;
                default: COUNT = CNT_W'($urandom);
            endcase
            din = 4'($urandom);
`ifdef SEQ_ABORT_EN
            ABORT = ($urandom_range(0, 19) == 0);
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
